// File: rtl/aurora_rx_merger_if.sv
// Merger bus: per-channel Aurora RX inputs, merged output handshake and drop statistics.
// The merger takes the slave view; the producer/consumer side takes the master view.
interface aurora_rx_merger_if #(
   parameter int CNO   = 8,
   parameter int DW    = 32,
   parameter int CHW   = 3,
   parameter int CNT_W = 16
);
   logic [DW*CNO-1:0]    rx_d;
   logic [CNO-1:0]       rx_src_rdy_n;
   logic [CNO-1:0]       channel_up;
   logic [DW-1:0]        out_d;
   logic [CHW-1:0]       out_ch;
   logic                 out_src_rdy_n;
   logic                 out_dst_rdy_n;
   logic [CNO-1:0]       fifo_full;
   logic [CNO-1:0]       overflow;
   logic [CNT_W*CNO-1:0] ovf_count;
   logic                 clear_stats;

   modport master (
      output rx_d, rx_src_rdy_n, channel_up, out_dst_rdy_n, clear_stats,
      input  out_d, out_ch, out_src_rdy_n, fifo_full, overflow, ovf_count
   );

   modport slave (
      input  rx_d, rx_src_rdy_n, channel_up, out_dst_rdy_n, clear_stats,
      output out_d, out_ch, out_src_rdy_n, fifo_full, overflow, ovf_count
   );
endinterface

// File: rtl/aurora_rx_merger.sv
// Merges CNO Aurora RX channels through per-channel FIFOs and a round-robin arbiter
// into one registered output stream; full FIFOs drop and count, down channels flush.
module aurora_rx_merger #(
   parameter int CNO   = 8,
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int CHW   = 3,
   parameter int CNT_W = 16
) (
   input logic             user_clk,
   input logic             reset,
   aurora_rx_merger_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [CNO-1:0]    w_flush, w_wr, w_drop, w_elig, w_rd;
   logic [DW*CNO-1:0] w_head;
   logic [2*CNO-1:0]  w_dbl;
   logic [CNO-1:0]    w_rot;
   logic [CHW-1:0]    w_start, w_gnt;
   logic              w_gnt_vld, w_load;
   logic [DW-1:0]     w_mux;
   int                w_off, w_sum;

   logic              r_vld;
   logic [DW-1:0]     r_dat;
   logic [CHW-1:0]    r_ch, r_last;

   // The output register reloads whenever it is empty or its word leaves this cycle.
   assign w_load = ~r_vld | ~bus.out_dst_rdy_n;

   for (genvar i = 0; i < CNO; i++) begin : g_ch
      logic [DW-1:0]    r_mem [DEPTH];
      logic [AW-1:0]    r_wptr, r_rptr;
      logic [AW:0]      r_occ, w_occ_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic             r_full, r_ovf;

      assign w_flush[i] = ~bus.channel_up[i];
      assign w_wr[i]    = ~bus.rx_src_rdy_n[i] & bus.channel_up[i] & (r_occ != FULL_OCC);
      assign w_drop[i]  = ~bus.rx_src_rdy_n[i] & bus.channel_up[i] & (r_occ == FULL_OCC);
      assign w_elig[i]  = bus.channel_up[i] & (r_occ != '0);
      assign w_rd[i]    = w_load & w_gnt_vld & (w_gnt == CHW'(i));
      assign w_head[DW*i +: DW] = r_mem[r_rptr];

      always_comb begin
         w_occ_nxt = r_occ;
         if (w_flush[i])
            w_occ_nxt = '0;
         else if (w_wr[i] && !w_rd[i])
            w_occ_nxt = r_occ + (AW+1)'(1);
         else if (!w_wr[i] && w_rd[i])
            w_occ_nxt = r_occ - (AW+1)'(1);
      end

      always_ff @(posedge user_clk or posedge reset) begin
         if (reset) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_full <= 1'b0;
         end else begin
            r_occ  <= w_occ_nxt;
            r_full <= (w_occ_nxt == FULL_OCC);
            if (w_flush[i]) begin
               r_wptr <= '0;
               r_rptr <= '0;
            end else begin
               if (w_wr[i]) r_wptr <= r_wptr + AW'(1);
               if (w_rd[i]) r_rptr <= r_rptr + AW'(1);
            end
         end
      end

      always_ff @(posedge user_clk) begin
         if (w_wr[i]) r_mem[r_wptr] <= bus.rx_d[DW*i +: DW];
      end

      // Clear takes priority over a drop on the same edge.
      always_ff @(posedge user_clk or posedge reset) begin
         if (reset) begin
            r_ovf <= 1'b0;
            r_cnt <= '0;
         end else if (bus.clear_stats) begin
            r_ovf <= 1'b0;
            r_cnt <= '0;
         end else if (w_drop[i]) begin
            r_ovf <= 1'b1;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      assign bus.fifo_full[i]                 = r_full;
      assign bus.overflow[i]                  = r_ovf;
      assign bus.ovf_count[CNT_W*i +: CNT_W]  = r_cnt;
   end

   // Rotate eligibility so the channel after the last grant sits at bit 0.
   assign w_start = (r_last == CHW'(CNO-1)) ? '0 : r_last + CHW'(1);
   assign w_dbl   = {w_elig, w_elig} >> w_start;
   assign w_rot   = w_dbl[CNO-1:0];

   always_comb begin
      w_off     = 0;
      w_gnt_vld = |w_rot;
      for (int j = CNO-1; j >= 0; j--) begin
         if (w_rot[j]) w_off = j;
      end
      w_sum = int'(w_start) + w_off;
      if (w_sum >= CNO) w_sum = w_sum - CNO;
      w_gnt = CHW'(w_sum);
   end

   always_comb begin
      w_mux = '0;
      for (int j = 0; j < CNO; j++) begin
         if (w_gnt == CHW'(j)) w_mux = w_head[DW*j +: DW];
      end
   end

   always_ff @(posedge user_clk or posedge reset) begin
      if (reset) begin
         r_vld  <= 1'b0;
         r_dat  <= '0;
         r_ch   <= '0;
         r_last <= CHW'(CNO-1);
      end else if (w_load) begin
         r_vld <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_dat  <= w_mux;
            r_ch   <= w_gnt;
            r_last <= w_gnt;
         end
      end
   end

   assign bus.out_src_rdy_n = ~r_vld;
   assign bus.out_d         = r_dat;
   assign bus.out_ch        = r_ch;
endmodule
